// File: rtl/set_bit_grant_scheduler.sv
// Batch grant scheduler. It snapshots a request bitmap and then hands out one grant per set bit,
// starting below the last granted index and wrapping, over a valid/ready handshake.
module set_bit_grant_scheduler #(
  parameter int NUM_PORTS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_PORTS-1:0] req_vec,
  input  logic                 abort,
  input  logic                 grant_ready,
  output logic                 grant_valid,
  output logic [$clog2(NUM_PORTS)-1:0] grant_idx,
  output logic [NUM_PORTS-1:0] grant_onehot,
  output logic                 busy,
  output logic                 done,
  output logic [$clog2(NUM_PORTS):0] grant_count
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    DONE
  } state_e;

  state_e               state_q;
  logic [NUM_PORTS-1:0] pending_q;
  logic [IDX_W-1:0]     ptr_q;
  logic [IDX_W:0]       count_q;

  logic [IDX_W-1:0]     lo_idx;
  logic [IDX_W-1:0]     any_idx;
  logic                 lo_found;
  logic [IDX_W-1:0]     sel_idx;
  logic [NUM_PORTS-1:0] sel_onehot;
  logic [NUM_PORTS-1:0] pending_after;
  logic [IDX_W-1:0]     ptr_d;

  // Ascending scan so the last hit is the highest set bit, both at-or-below ptr and overall.
  always_comb begin
    lo_idx   = '0;
    any_idx  = '0;
    lo_found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (pending_q[i]) begin
        any_idx = IDX_W'(i);
        if (IDX_W'(i) <= ptr_q) begin
          lo_idx   = IDX_W'(i);
          lo_found = 1'b1;
        end
      end
    end
  end

  // Explicit wrap keeps the pointer decrement correct for non-power-of-2 port counts.
  always_comb begin
    sel_idx       = lo_found ? lo_idx : any_idx;
    sel_onehot    = NUM_PORTS'(1) << sel_idx;
    pending_after = pending_q & ~sel_onehot;
    ptr_d         = (sel_idx == '0) ? IDX_W'(NUM_PORTS - 1) : sel_idx - IDX_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      ptr_q     <= IDX_W'(NUM_PORTS - 1);
      count_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            pending_q <= req_vec;
            count_q   <= '0;
            state_q   <= (req_vec != '0) ? GRANT : DONE;
          end
        end
        GRANT: begin
          if (abort) begin
            state_q   <= IDLE;
            pending_q <= '0;
          end else if (grant_ready) begin
            pending_q <= pending_after;
            count_q   <= count_q + (IDX_W+1)'(1);
            ptr_q     <= ptr_d;
            if (pending_after == '0) begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          state_q   <= IDLE;
          pending_q <= '0;
        end
        default: begin
          state_q   <= IDLE;
          pending_q <= '0;
        end
      endcase
    end
  end

  assign grant_valid  = (state_q == GRANT);
  assign grant_idx    = grant_valid ? sel_idx : '0;
  assign grant_onehot = grant_valid ? sel_onehot : '0;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign grant_count  = count_q;

endmodule

// File: tb/tb_set_bit_grant_scheduler.sv
// Directed bench for set_bit_grant_scheduler: grant order, pointer wrap, backpressure,
// empty batch, abort / ignored start and asynchronous reset.
module tb_set_bit_grant_scheduler;

  localparam int NUM_PORTS = 8;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] req_vec;
  logic       abort;
  logic       grant_ready;
  logic       grant_valid;
  logic [2:0] grant_idx;
  logic [7:0] grant_onehot;
  logic       busy;
  logic       done;
  logic [3:0] grant_count;

  int tests  = 0;
  int failed = 0;

  set_bit_grant_scheduler #(.NUM_PORTS(NUM_PORTS)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .req_vec      (req_vec),
    .abort        (abort),
    .grant_ready  (grant_ready),
    .grant_valid  (grant_valid),
    .grant_idx    (grant_idx),
    .grant_onehot (grant_onehot),
    .busy         (busy),
    .done         (done),
    .grant_count  (grant_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks a run of expected grants with grant_ready held high, then the done pulse.
  task automatic expect_grants(input string name, input int idxs[$], input int expCount);
    for (int k = 0; k < idxs.size(); k++) begin
      tests++;
      if (grant_valid !== 1'b1 || grant_idx !== 3'(idxs[k]) || grant_onehot !== (8'h01 << idxs[k])) begin
        failed++;
        $display("[TB] FAIL %s grant%0d: valid=%b idx=%0d onehot=%h, want valid=1 idx=%0d onehot=%h",
                 name, k, grant_valid, grant_idx, grant_onehot, idxs[k], 8'h01 << idxs[k]);
      end
      tick();
    end
    tests++;
    if (done !== 1'b1 || grant_valid !== 1'b0 || grant_count !== 4'(expCount)) begin
      failed++;
      $display("[TB] FAIL %s done: done=%b valid=%b count=%0d, want done=1 valid=0 count=%0d",
               name, done, grant_valid, grant_count, expCount);
    end
    tick();
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || grant_count !== 4'(expCount)) begin
      failed++;
      $display("[TB] FAIL %s idle: done=%b busy=%b count=%0d, want done=0 busy=0 count=%0d",
               name, done, busy, grant_count, expCount);
    end
  endtask

  task automatic start_batch(input logic [7:0] req);
    start   = 1'b1;
    req_vec = req;
    tick();
    start   = 1'b0;
    req_vec = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    tests++;
    if ({grant_valid, grant_idx, grant_onehot, busy, done, grant_count} !== 19'd0) begin
      failed++;
      $display("[TB] FAIL reset_outputs: got %h, want 0",
               {grant_valid, grant_idx, grant_onehot, busy, done, grant_count});
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic_order();
    grant_ready = 1'b1;
    start_batch(8'hA5);
    expect_grants("basic_order", '{7, 5, 2, 0}, 4);
  endtask

  task automatic test_pointer_persistence();
    grant_ready = 1'b1;
    start_batch(8'h24);
    expect_grants("ptr_first", '{5, 2}, 2);
    start_batch(8'h81);
    expect_grants("ptr_wrap", '{0, 7}, 2);
  endtask

  // ptr is 6 here, so bit 4 of 8'h12 goes first.
  task automatic test_backpressure();
    grant_ready = 1'b0;
    start_batch(8'h12);
    for (int c = 0; c < 3; c++) begin
      tests++;
      if (grant_valid !== 1'b1 || grant_idx !== 3'd4 || grant_onehot !== 8'h10 || grant_count !== 4'd0) begin
        failed++;
        $display("[TB] FAIL backpressure_hold%0d: valid=%b idx=%0d onehot=%h count=%0d, want 1/4/10/0",
                 c, grant_valid, grant_idx, grant_onehot, grant_count);
      end
      tick();
    end
    grant_ready = 1'b1;
    tests++;
    if (grant_idx !== 3'd4 || grant_count !== 4'd0) begin
      failed++;
      $display("[TB] FAIL backpressure_release: idx=%0d count=%0d, want 4/0", grant_idx, grant_count);
    end
    tick();
    tests++;
    if (grant_idx !== 3'd1 || grant_count !== 4'd1) begin
      failed++;
      $display("[TB] FAIL backpressure_advance: idx=%0d count=%0d, want 1/1", grant_idx, grant_count);
    end
    expect_grants("backpressure_tail", '{1}, 2);
  endtask

  task automatic test_empty_batch();
    grant_ready = 1'b1;
    start_batch(8'h00);
    expect_grants("empty_batch", '{}, 0);
  endtask

  // ptr is 0 after the backpressure batch, so 8'h09 grants bit 0 first.
  task automatic test_abort_ignored_start();
    grant_ready = 1'b0;
    start_batch(8'h09);
    start   = 1'b1;
    req_vec = 8'hF0;
    tick();
    start   = 1'b0;
    req_vec = 8'h00;
    tests++;
    if (grant_valid !== 1'b1 || grant_idx !== 3'd0 || grant_count !== 4'd0) begin
      failed++;
      $display("[TB] FAIL ignored_start: valid=%b idx=%0d count=%0d, want 1/0/0",
               grant_valid, grant_idx, grant_count);
    end
    grant_ready = 1'b1;
    tick();
    tests++;
    if (grant_idx !== 3'd3 || grant_count !== 4'd1) begin
      failed++;
      $display("[TB] FAIL abort_pre: idx=%0d count=%0d, want 3/1", grant_idx, grant_count);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tests++;
    if (busy !== 1'b0 || grant_valid !== 1'b0 || done !== 1'b0 || grant_count !== 4'd1) begin
      failed++;
      $display("[TB] FAIL abort_idle: busy=%b valid=%b done=%b count=%0d, want 0/0/0/1",
               busy, grant_valid, done, grant_count);
    end
    tick();
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failed++;
      $display("[TB] FAIL abort_no_done: done=%b busy=%b, want 0/0", done, busy);
    end
    start_batch(8'h88);
    expect_grants("after_abort", '{7, 3}, 2);
  endtask

  // ptr is 2 after the previous batch.
  task automatic test_async_reset();
    grant_ready = 1'b0;
    start_batch(8'hFF);
    tests++;
    if (grant_valid !== 1'b1 || grant_idx !== 3'd2) begin
      failed++;
      $display("[TB] FAIL async_pre: valid=%b idx=%0d, want 1/2", grant_valid, grant_idx);
    end
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if ({grant_valid, grant_idx, grant_onehot, busy, done, grant_count} !== 19'd0) begin
      failed++;
      $display("[TB] FAIL async_reset_outputs: got %h, want 0",
               {grant_valid, grant_idx, grant_onehot, busy, done, grant_count});
    end
    tick();
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failed++;
      $display("[TB] FAIL async_no_done: done=%b busy=%b, want 0/0", done, busy);
    end
    rst = 1'b1;
    tick();
    grant_ready = 1'b1;
    start_batch(8'h81);
    expect_grants("async_ptr_reset", '{7, 0}, 2);
  endtask

  initial begin
    start       = 1'b0;
    req_vec     = 8'h00;
    abort       = 1'b0;
    grant_ready = 1'b0;
    rst         = 1'b0;
    test_reset();
    test_basic_order();
    test_pointer_persistence();
    test_backpressure();
    test_empty_batch();
    test_abort_ignored_start();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
